// File: rtl/block_fb_pkg.sv
// Shared types and helpers for the block-pixel double frame buffer.
package block_fb_pkg;

    // Write-side FSM: accepting words, filling the back bank, or holding a finished frame.
    typedef enum logic [1:0] {
        WRITE     = 2'd0,
        CLEARING  = 2'd1,
        WAIT_SWAP = 2'd2
    } fb_state_e;

    // log2 of a power-of-two block edge, used to turn pixel coordinates into block coordinates.
    function automatic int log2_int(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Row-major block index.
    function automatic int block_index(input int row, input int col, input int hblocks);
        return row * hblocks + col;
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
module fb_bank_ram #(
    parameter int DEPTH  = 1200,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write and registered read share the edge; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/block_frame_buffer.sv
// Double frame buffer for the block-pixel VGA path: handshaked back-bank writes,
// hardware clear, bank swap in vertical blanking, 2-cycle registered read path.
module block_frame_buffer
    import block_fb_pkg::*;
#(
    parameter int                  HPIXELS     = 640,
    parameter int                  VPIXELS     = 480,
    parameter int                  BLOCK_SIZE  = 16,
    parameter int                  PIXEL_W     = 8,
    parameter logic [PIXEL_W-1:0]  CLEAR_VALUE = '0,
    parameter int                  HBLOCKS     = HPIXELS / BLOCK_SIZE,
    parameter int                  VBLOCKS     = VPIXELS / BLOCK_SIZE,
    parameter int                  BUFFER_SIZE = HBLOCKS * VBLOCKS,
    parameter int                  ADDR_W      = $clog2(BUFFER_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               wr_last,
    input  logic               clr_req,
    output logic [PIXEL_W-1:0] pix_out,
    output logic               pix_active,
    output logic               front_bank,
    output logic               swap_pulse
);

    localparam int                LOG2_BS   = log2_int(BLOCK_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUFFER_SIZE - 1);

    // Write handshake: a word transfers on a rising edge where wr_valid and wr_ready
    // are both high. wr_ready depends only on the FSM state and clr_req, never on
    // wr_valid. The producer holds wr_addr/wr_data/wr_last stable while wr_valid is
    // high and not yet accepted. Out-of-range addresses complete the handshake but
    // are not written.

    fb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               front_bank_q, front_bank_d;
    logic               swap_pulse_q, swap_pulse_d;

    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_vis_q, rd_vis_d;
    logic               rd_bank_q, rd_bank_d;
    logic               pix_active_q, pix_active_d;
    logic               pix_bank_q, pix_bank_d;

    logic               wr_fire;
    logic               wr_in_range;
    logic               at_boundary;
    logic               bank_we;
    logic [ADDR_W-1:0]  bank_waddr;
    logic [PIXEL_W-1:0] bank_wdata;
    logic [PIXEL_W-1:0] rdata0, rdata1;

    assign wr_ready    = (state_q == WRITE) && !clr_req;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = int'(wr_addr) < BUFFER_SIZE;
    assign at_boundary = (hc == 10'd0) && (vc == 10'(VPIXELS));

    // Next-state logic for the write FSM, clear counter and bank selection.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        front_bank_d = front_bank_q;
        swap_pulse_d = 1'b0;
        case (state_q)
            WRITE: begin
                if (clr_req) begin
                    state_d   = CLEARING;
                    clr_cnt_d = '0;
                end else if (wr_fire && wr_last) begin
                    state_d = WAIT_SWAP;
                end
            end
            CLEARING: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = WRITE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            WAIT_SWAP: begin
                if (at_boundary) begin
                    state_d      = WRITE;
                    front_bank_d = ~front_bank_q;
                    swap_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = WRITE;
            end
        endcase
    end

    // FSM, clear counter, displayed bank and swap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WRITE;
            clr_cnt_q    <= '0;
            front_bank_q <= 1'b0;
            swap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            front_bank_q <= front_bank_d;
            swap_pulse_q <= swap_pulse_d;
        end
    end

    // Back-bank write steering: the clear counter owns the port while clearing.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = wr_addr;
        bank_wdata = wr_data;
        if (state_q == CLEARING) begin
            bank_we    = 1'b1;
            bank_waddr = clr_cnt_q;
            bank_wdata = CLEAR_VALUE;
        end else if (wr_fire && wr_in_range) begin
            bank_we = 1'b1;
        end
    end

    // Read pipeline next values: block address, visibility and bank tag travel together.
    always_comb begin
        rd_vis_d     = (hc < 10'(HPIXELS)) && (vc < 10'(VPIXELS));
        rd_addr_d    = '0;
        if (rd_vis_d) begin
            rd_addr_d = ADDR_W'(block_index(int'(vc >> LOG2_BS), int'(hc >> LOG2_BS), HBLOCKS));
        end
        rd_bank_d    = front_bank_q;
        pix_active_d = rd_vis_q;
        pix_bank_d   = rd_bank_q;
    end

    // Read pipeline registers: stage 1 address, stage 2 alongside the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q    <= '0;
            rd_vis_q     <= 1'b0;
            rd_bank_q    <= 1'b0;
            pix_active_q <= 1'b0;
            pix_bank_q   <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            rd_vis_q     <= rd_vis_d;
            rd_bank_q    <= rd_bank_d;
            pix_active_q <= pix_active_d;
            pix_bank_q   <= pix_bank_d;
        end
    end

    fb_bank_ram #(
        .DEPTH  (BUFFER_SIZE),
        .WIDTH  (PIXEL_W),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (bank_we && front_bank_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr_q),
        .rdata (rdata0)
    );

    fb_bank_ram #(
        .DEPTH  (BUFFER_SIZE),
        .WIDTH  (PIXEL_W),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (bank_we && !front_bank_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr_q),
        .rdata (rdata1)
    );

    assign pix_out    = pix_active_q ? (pix_bank_q ? rdata1 : rdata0) : '0;
    assign pix_active = pix_active_q;
    assign front_bank = front_bank_q;
    assign swap_pulse = swap_pulse_q;

endmodule

// File: tb/tb_block_frame_buffer.sv
// Bench for block_frame_buffer: directed write/swap/clear/reset scenarios with a
// pixel scoreboard fed by the read driver and drained by a 2-cycle-delayed monitor.
module tb_block_frame_buffer;

    localparam int ADDR_W  = 11;
    localparam int PIXEL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [9:0]         hc;
    logic [9:0]         vc;
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIXEL_W-1:0] wr_data;
    logic               wr_last;
    logic               clr_req;
    logic [PIXEL_W-1:0] pix_out;
    logic               pix_active;
    logic               front_bank;
    logic               swap_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_word;
    logic       probe    = 1'b0;
    logic       probe_d1 = 1'b0;
    logic       probe_d2 = 1'b0;

    block_frame_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hc         (hc),
        .vc         (vc),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .clr_req    (clr_req),
        .pix_out    (pix_out),
        .pix_active (pix_active),
        .front_bank (front_bank),
        .swap_pulse (swap_pulse)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Probe delay line: a read sample's result appears two edges later.
    always @(posedge clk) begin
        probe_d1 <= probe;
        probe_d2 <= probe_d1;
    end

    // Monitor: compare each delayed sample against the scoreboard head.
    always @(negedge clk) begin
        if (probe_d2) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL pix_unexpected: got active=%0d pix=0x%0h, expected no sample", pix_active, pix_out);
            end else begin
                exp_word = exp_q.pop_front();
                check("pix_active", 32'(pix_active), 32'(exp_word[8]));
                check("pix_out", 32'(pix_out), 32'(exp_word[7:0]));
            end
        end
    end

    task automatic set_idle();
        hc = 10'd700;
        vc = 10'd500;
    endtask

    // Driver: present one read sample for one cycle and record its expected result.
    task automatic read_px(input int h, input int v, input logic act, input logic [7:0] pix);
        hc    = 10'(h);
        vc    = 10'(v);
        probe = 1'b1;
        exp_q.push_back({act, pix});
        @(negedge clk);
        probe = 1'b0;
        set_idle();
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // Driver: offer one word; it must be accepted on the next edge.
    task automatic write_word(input int a, input int d, input logic last);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_data  = PIXEL_W'(d);
        wr_last  = last;
        #1;
        check("wr_ready_on_offer", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Driver: one cycle at the first blanking line, then check bank and pulse.
    task automatic boundary(input logic exp_front, input logic exp_swap);
        hc = 10'd0;
        vc = 10'd480;
        @(negedge clk);
        set_idle();
        check("front_bank_after_boundary", 32'(front_bank), 32'(exp_front));
        check("swap_pulse_after_boundary", 32'(swap_pulse), 32'(exp_swap));
        @(negedge clk);
        check("swap_pulse_one_cycle", 32'(swap_pulse), 32'd0);
    endtask

    initial begin
        int cnt;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_last  = 1'b0;
        clr_req  = 1'b0;
        set_idle();

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_front_bank", 32'(front_bank), 32'd0);
        check("rst_swap_pulse", 32'(swap_pulse), 32'd0);
        check("rst_pix_active", 32'(pix_active), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);

        // Write a full frame with data = addr[7:0], then swap
        for (int a = 0; a < 1200; a++) begin
            write_word(a, a & 255, a == 1199);
        end
        #1;
        check("wr_ready_after_last", 32'(wr_ready), 32'd0);
        check("front_before_swap", 32'(front_bank), 32'd0);
        boundary(1'b1, 1'b1);
        check("wr_ready_after_swap", 32'(wr_ready), 32'd1);
        read_px(17, 16, 1'b1, 8'h29);
        read_px(0, 0, 1'b1, 8'h00);
        read_px(16, 0, 1'b1, 8'h01);
        read_px(639, 479, 1'b1, 8'hAF);
        read_px(320, 240, 1'b1, 8'h6C);
        read_px(700, 10, 1'b0, 8'h00);
        read_px(15, 15, 1'b1, 8'h00);
        drain();

        // No pending frame: three boundaries repeat the same front frame
        for (int f = 0; f < 3; f++) begin
            boundary(1'b1, 1'b0);
            read_px(17, 16, 1'b1, 8'h29);
            read_px(639, 479, 1'b1, 8'hAF);
            drain();
        end

        // Clear the back bank; a mid-clear request must not restart it
        clr_req = 1'b1;
        #1;
        check("wr_ready_with_clr_req", 32'(wr_ready), 32'd0);
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        cnt = 0;
        while (wr_ready == 1'b0 && cnt < 3000) begin
            clr_req = (cnt == 600);
            @(negedge clk);
            clr_req = 1'b0;
            #1;
            cnt++;
        end
        check("clear_busy_cycles", 32'(cnt), 32'd1200);
        write_word(5, 8'h55, 1'b1);
        #1;
        check("wr_ready_wait_swap", 32'(wr_ready), 32'd0);
        boundary(1'b0, 1'b1);
        read_px(17, 16, 1'b1, 8'h00);
        read_px(639, 479, 1'b1, 8'h00);
        read_px(80, 0, 1'b1, 8'h55);
        read_px(0, 0, 1'b1, 8'h00);
        read_px(320, 240, 1'b1, 8'h00);
        drain();

        // Out-of-range write handshakes and is dropped
        write_word(1500, 8'hEE, 1'b0);
        #1;
        check("wr_ready_after_oor", 32'(wr_ready), 32'd1);

        // Late completion: wr_last accepted on the boundary cycle
        hc = 10'd0;
        vc = 10'd480;
        write_word(41, 8'h99, 1'b1);
        set_idle();
        #1;
        check("late_front_bank", 32'(front_bank), 32'd0);
        check("late_swap_pulse", 32'(swap_pulse), 32'd0);
        check("late_wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        check("late_swap_pulse_2", 32'(swap_pulse), 32'd0);
        boundary(1'b1, 1'b1);
        read_px(17, 16, 1'b1, 8'h99);
        read_px(0, 0, 1'b1, 8'h00);
        read_px(639, 479, 1'b1, 8'hAF);
        read_px(320, 112, 1'b1, 8'h2C);
        read_px(700, 100, 1'b0, 8'h00);
        drain();

        // Reset during CLEARING
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        hc = 10'd17;
        vc = 10'd16;
        repeat (3) @(negedge clk);
        check("midclear_wr_ready", 32'(wr_ready), 32'd0);
        check("midclear_pix_active", 32'(pix_active), 32'd1);
        check("midclear_pix_out", 32'(pix_out), 32'h99);
        rst_n = 1'b0;
        #1;
        check("rst_clear_front_bank", 32'(front_bank), 32'd0);
        check("rst_clear_pix_active", 32'(pix_active), 32'd0);
        check("rst_clear_pix_out", 32'(pix_out), 32'd0);
        check("rst_clear_swap_pulse", 32'(swap_pulse), 32'd0);
        check("rst_clear_wr_ready", 32'(wr_ready), 32'd1);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_rst_clear_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);

        // Reset during WAIT_SWAP
        write_word(0, 8'h11, 1'b1);
        #1;
        check("midwait_wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wait_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_wait_front_bank", 32'(front_bank), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        boundary(1'b0, 1'b0);

        // Final report
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
